// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//
// Single-entry issue buffer that sits between decode and the ALU. It holds one
// decoded instruction, resolves its two source operands against the EX/MEM and
// WB forwarding buses, stalls on a load-use hazard against the EX/MEM stage, and
// hands the resolved operands to the ALU under a valid/ready handshake.
//
// Ports
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   id_*                upstream decode beat (valid/ready handshake)
//   flush               kills the held entry and discards the upstream beat
//   fwd_exm_*           EX/MEM forwarding bus (is_load marks a not-yet-ready value)
//   fwd_wb_*            writeback forwarding bus
//   ex_ready, ex_valid  downstream ALU handshake
//   alu_a, alu_b        resolved operands (alu_b is the zero-extended imm when use_imm)
//   alu_ctrl, ex_rd_addr, ex_wr_en
//                       passed through from the held entry
//   stall_cnt           saturating count of load-use stall cycles
// -----------------------------------------------------------------------------
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        id_valid,
    output logic        id_ready,
    input  logic [4:0]  id_ctrl,
    input  logic [3:0]  id_rs_addr,
    input  logic [3:0]  id_rt_addr,
    input  logic [3:0]  id_rd_addr,
    input  logic [15:0] id_rs_data,
    input  logic [15:0] id_rt_data,
    input  logic [7:0]  id_imm,
    input  logic        id_use_imm,
    input  logic        id_wr_en,

    input  logic        flush,

    input  logic        fwd_exm_valid,
    input  logic        fwd_exm_is_load,
    input  logic [3:0]  fwd_exm_addr,
    input  logic [15:0] fwd_exm_data,

    input  logic        fwd_wb_valid,
    input  logic [3:0]  fwd_wb_addr,
    input  logic [15:0] fwd_wb_data,

    input  logic        ex_ready,
    output logic        ex_valid,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [4:0]  alu_ctrl,
    output logic [3:0]  ex_rd_addr,
    output logic        ex_wr_en,

    output logic [15:0] stall_cnt
);

    typedef struct packed {
        logic        valid;
        logic [4:0]  ctrl;
        logic [3:0]  rs_addr;
        logic [3:0]  rt_addr;
        logic [3:0]  rd_addr;
        logic [15:0] rs_data;
        logic [15:0] rt_data;
        logic [7:0]  imm;
        logic        use_imm;
        logic        wr_en;
    } entry_t;

    entry_t      entry_q, entry_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic        use_rt;
    logic        hazard;
    logic        fire;
    logic [15:0] rs_resolved;
    logic [15:0] rt_resolved;

    // Register 0 is hard-wired to zero, so it never matches a forwarding bus.
    function automatic logic [15:0] resolve_operand(
        input logic [3:0]  addr,
        input logic [15:0] stored,
        input logic        exm_valid,
        input logic        exm_is_load,
        input logic [3:0]  exm_addr,
        input logic [15:0] exm_data,
        input logic        wb_valid,
        input logic [3:0]  wb_addr,
        input logic [15:0] wb_data
    );
        logic [15:0] result;
        result = stored;
        if (addr == 4'd0) begin
            result = 16'h0000;
        end else if (exm_valid && !exm_is_load && (exm_addr == addr)) begin
            result = exm_data;
        end else if (wb_valid && (wb_addr == addr)) begin
            result = wb_data;
        end
        return result;
    endfunction

    // Capture a retiring WB write into a stored operand so it is not lost while
    // the entry waits (or while it is being captured).
    function automatic logic [15:0] wb_merge(
        input logic [3:0]  addr,
        input logic [15:0] stored,
        input logic        wb_valid,
        input logic [3:0]  wb_addr,
        input logic [15:0] wb_data
    );
        return (wb_valid && (addr != 4'd0) && (wb_addr == addr)) ? wb_data : stored;
    endfunction

    // ------------------------------------------------------------------------
    // Handshake and hazard detection
    // ------------------------------------------------------------------------
    assign use_rt = !entry_q.use_imm;

    // Only a load in EX/MEM can stall: its data is not on the bus yet. An
    // immediate-form instruction ignores rt, so an rt match there is harmless.
    assign hazard = entry_q.valid && fwd_exm_valid && fwd_exm_is_load &&
                    (fwd_exm_addr != 4'd0) &&
                    ((fwd_exm_addr == entry_q.rs_addr) ||
                     (use_rt && (fwd_exm_addr == entry_q.rt_addr)));

    assign ex_valid  = entry_q.valid && !hazard && !flush;
    assign fire      = ex_valid && ex_ready;
    assign id_ready  = !entry_q.valid || fire || flush;
    assign stall_cnt = stall_cnt_q;

    // ------------------------------------------------------------------------
    // Operand resolution and output drive
    // ------------------------------------------------------------------------
    assign rs_resolved = resolve_operand(entry_q.rs_addr, entry_q.rs_data,
                                         fwd_exm_valid, fwd_exm_is_load, fwd_exm_addr, fwd_exm_data,
                                         fwd_wb_valid, fwd_wb_addr, fwd_wb_data);
    assign rt_resolved = resolve_operand(entry_q.rt_addr, entry_q.rt_data,
                                         fwd_exm_valid, fwd_exm_is_load, fwd_exm_addr, fwd_exm_data,
                                         fwd_wb_valid, fwd_wb_addr, fwd_wb_data);

    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // branch; a path that leaves one unassigned would infer a latch.
        alu_a      = 16'h0000;
        alu_b      = 16'h0000;
        alu_ctrl   = 5'd0;
        ex_rd_addr = 4'd0;
        ex_wr_en   = 1'b0;
        if (entry_q.valid) begin
            alu_a      = rs_resolved;
            alu_b      = entry_q.use_imm ? {8'h00, entry_q.imm} : rt_resolved;
            alu_ctrl   = entry_q.ctrl;
            ex_rd_addr = entry_q.rd_addr;
            ex_wr_en   = entry_q.wr_en;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        entry_d     = entry_q;
        stall_cnt_d = stall_cnt_q;

        if (entry_q.valid && hazard && !flush && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end

        if (flush) begin
            // Flush wins over both capture and issue; the upstream beat is lost.
            entry_d.valid = 1'b0;
        end else if (id_valid && id_ready) begin
            entry_d.valid   = 1'b1;
            entry_d.ctrl    = id_ctrl;
            entry_d.rs_addr = id_rs_addr;
            entry_d.rt_addr = id_rt_addr;
            entry_d.rd_addr = id_rd_addr;
            entry_d.rs_data = wb_merge(id_rs_addr, id_rs_data, fwd_wb_valid, fwd_wb_addr, fwd_wb_data);
            entry_d.rt_data = wb_merge(id_rt_addr, id_rt_data, fwd_wb_valid, fwd_wb_addr, fwd_wb_data);
            entry_d.imm     = id_imm;
            entry_d.use_imm = id_use_imm;
            entry_d.wr_en   = id_wr_en;
        end else if (fire) begin
            entry_d.valid = 1'b0;
        end else if (entry_q.valid) begin
            entry_d.rs_data = wb_merge(entry_q.rs_addr, entry_q.rs_data, fwd_wb_valid, fwd_wb_addr, fwd_wb_data);
            entry_d.rt_data = wb_merge(entry_q.rt_addr, entry_q.rt_data, fwd_wb_valid, fwd_wb_addr, fwd_wb_data);
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the payload fields are reset along with the valid bit so that a
        // freshly reset stage presents all-zero state, not leftover data.
        if (!rst_n) begin
            entry_q     <= '0;
            stall_cnt_q <= 16'h0000;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its _d value from before the edge.
            entry_q     <= entry_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Directed scenarios followed by a randomized run. Expected values come from a
// behavioural model of the held instruction: its fields, a view of the register
// file through the forwarding buses, and a stall counter.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic        id_ready;
    logic [4:0]  id_ctrl = '0;
    logic [3:0]  id_rs_addr = '0;
    logic [3:0]  id_rt_addr = '0;
    logic [3:0]  id_rd_addr = '0;
    logic [15:0] id_rs_data = '0;
    logic [15:0] id_rt_data = '0;
    logic [7:0]  id_imm = '0;
    logic        id_use_imm = 1'b0;
    logic        id_wr_en = 1'b0;
    logic        flush = 1'b0;
    logic        fwd_exm_valid = 1'b0;
    logic        fwd_exm_is_load = 1'b0;
    logic [3:0]  fwd_exm_addr = '0;
    logic [15:0] fwd_exm_data = '0;
    logic        fwd_wb_valid = 1'b0;
    logic [3:0]  fwd_wb_addr = '0;
    logic [15:0] fwd_wb_data = '0;
    logic        ex_ready = 1'b1;
    logic        ex_valid;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [4:0]  alu_ctrl;
    logic [3:0]  ex_rd_addr;
    logic        ex_wr_en;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    alu_issue_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_ctrl         (id_ctrl),
        .id_rs_addr      (id_rs_addr),
        .id_rt_addr      (id_rt_addr),
        .id_rd_addr      (id_rd_addr),
        .id_rs_data      (id_rs_data),
        .id_rt_data      (id_rt_data),
        .id_imm          (id_imm),
        .id_use_imm      (id_use_imm),
        .id_wr_en        (id_wr_en),
        .flush           (flush),
        .fwd_exm_valid   (fwd_exm_valid),
        .fwd_exm_is_load (fwd_exm_is_load),
        .fwd_exm_addr    (fwd_exm_addr),
        .fwd_exm_data    (fwd_exm_data),
        .fwd_wb_valid    (fwd_wb_valid),
        .fwd_wb_addr     (fwd_wb_addr),
        .fwd_wb_data     (fwd_wb_data),
        .ex_ready        (ex_ready),
        .ex_valid        (ex_valid),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_ctrl        (alu_ctrl),
        .ex_rd_addr      (ex_rd_addr),
        .ex_wr_en        (ex_wr_en),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Reference model: the instruction waiting for issue
    // ------------------------------------------------------------------------
    typedef struct {
        bit          valid;
        logic [4:0]  ctrl;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [3:0]  rd;
        logic [15:0] rs_val;
        logic [15:0] rt_val;
        logic [7:0]  imm;
        bit          use_imm;
        bit          wr_en;
    } instr_t;

    instr_t m;
    int     m_stalls;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Value of register r as the ALU should see it this cycle.
    function automatic logic [15:0] reg_view(input logic [3:0] r, input logic [15:0] held);
        if (r == 0) return 16'h0000;
        if (fwd_exm_valid && !fwd_exm_is_load && fwd_exm_addr == r) return fwd_exm_data;
        if (fwd_wb_valid && fwd_wb_addr == r) return fwd_wb_data;
        return held;
    endfunction

    // Value held after an edge at which WB may be retiring a write to r.
    function automatic logic [15:0] after_wb(input logic [3:0] r, input logic [15:0] held);
        return (fwd_wb_valid && r != 0 && fwd_wb_addr == r) ? fwd_wb_data : held;
    endfunction

    function automatic bit waits_on_load();
        bit reads_rt;
        reads_rt = !m.use_imm;
        return m.valid && fwd_exm_valid && fwd_exm_is_load && fwd_exm_addr != 0 &&
               (fwd_exm_addr == m.rs || (reads_rt && fwd_exm_addr == m.rt));
    endfunction

    function automatic bit exp_issue();
        return m.valid && !waits_on_load() && !flush;
    endfunction

    function automatic bit exp_accept();
        return !m.valid || (exp_issue() && ex_ready) || flush;
    endfunction

    task automatic model_reset();
        m        = '{default: '0};
        m_stalls = 0;
    endtask

    // Apply one rising edge to the model, using the inputs present at the edge.
    task automatic model_edge();
        bit issue_now;
        bit accept_now;
        issue_now  = exp_issue() && ex_ready;
        accept_now = exp_accept();
        if (m.valid && waits_on_load() && !flush && m_stalls < 65535) m_stalls++;
        if (flush) begin
            m.valid = 0;
        end else if (id_valid && accept_now) begin
            m.valid   = 1;
            m.ctrl    = id_ctrl;
            m.rs      = id_rs_addr;
            m.rt      = id_rt_addr;
            m.rd      = id_rd_addr;
            m.rs_val  = after_wb(id_rs_addr, id_rs_data);
            m.rt_val  = after_wb(id_rt_addr, id_rt_data);
            m.imm     = id_imm;
            m.use_imm = id_use_imm;
            m.wr_en   = id_wr_en;
        end else if (issue_now) begin
            m.valid = 0;
        end else if (m.valid) begin
            m.rs_val = after_wb(m.rs, m.rs_val);
            m.rt_val = after_wb(m.rt, m.rt_val);
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        exp_a = 16'h0000;
        exp_b = 16'h0000;
        if (m.valid) begin
            exp_a = reg_view(m.rs, m.rs_val);
            exp_b = m.use_imm ? {8'h00, m.imm} : reg_view(m.rt, m.rt_val);
        end
        check({tag, ".ex_valid"},   ex_valid,   exp_issue());
        check({tag, ".id_ready"},   id_ready,   exp_accept());
        check({tag, ".alu_a"},      alu_a,      exp_a);
        check({tag, ".alu_b"},      alu_b,      exp_b);
        check({tag, ".alu_ctrl"},   alu_ctrl,   m.valid ? m.ctrl : 5'd0);
        check({tag, ".ex_rd_addr"}, ex_rd_addr, m.valid ? m.rd : 4'd0);
        check({tag, ".ex_wr_en"},   ex_wr_en,   m.valid ? m.wr_en : 1'b0);
        check({tag, ".stall_cnt"},  stall_cnt,  m_stalls);
    endtask

    // Cycle helpers: inputs are changed 1 time unit after a rising edge;
    // outputs are sampled on the falling edge.
    task automatic to_negedge(input string tag);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic to_posedge();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step(input string tag);
        to_negedge(tag);
        to_posedge();
    endtask

    task automatic drive_beat(input logic [4:0] ctrl, input logic [3:0] rs, input logic [15:0] rs_d,
                              input logic [3:0] rt, input logic [15:0] rt_d, input logic [3:0] rd,
                              input logic [7:0] imm, input logic use_imm);
        id_valid   = 1'b1;
        id_ctrl    = ctrl;
        id_rs_addr = rs;
        id_rs_data = rs_d;
        id_rt_addr = rt;
        id_rt_data = rt_d;
        id_rd_addr = rd;
        id_imm     = imm;
        id_use_imm = use_imm;
        id_wr_en   = 1'b1;
    endtask

    task automatic clear_fwd();
        fwd_exm_valid   = 1'b0;
        fwd_exm_is_load = 1'b0;
        fwd_exm_addr    = '0;
        fwd_exm_data    = '0;
        fwd_wb_valid    = 1'b0;
        fwd_wb_addr     = '0;
        fwd_wb_data     = '0;
    endtask

    // Asynchronous reset pulse starting mid-cycle; outputs are checked while
    // reset is still low, then reset is released just after a rising edge.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, ".rst_ex_valid"}, ex_valid, 1'b0);
        check({tag, ".rst_id_ready"}, id_ready, 1'b1);
        check({tag, ".rst_stall"},    stall_cnt, 16'h0000);
        check({tag, ".rst_alu_a"},    alu_a, 16'h0000);
        check({tag, ".rst_alu_b"},    alu_b, 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();

        // ---------------- reset state ----------------
        #2;
        check("reset.ex_valid", ex_valid, 1'b0);
        check("reset.id_ready", id_ready, 1'b1);
        check("reset.stall_cnt", stall_cnt, 16'h0000);
        check("reset.alu_ctrl", alu_ctrl, 5'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("idle");

        // ---------------- back-to-back issue ----------------
        ex_ready = 1'b1;
        drive_beat(5'd0, 4'd1, 16'h0005, 4'd2, 16'h0003, 4'd6, 8'h00, 1'b0);
        step("b2b.cap");
        drive_beat(5'd1, 4'd7, 16'h0010, 4'd8, 16'h0020, 4'd9, 8'h00, 1'b0);
        to_negedge("b2b.first");
        check("b2b.ex_valid", ex_valid, 1'b1);
        check("b2b.alu_a", alu_a, 16'h0005);
        check("b2b.alu_b", alu_b, 16'h0003);
        check("b2b.alu_ctrl", alu_ctrl, 5'd0);
        check("b2b.id_ready", id_ready, 1'b1);
        to_posedge();
        id_valid = 1'b0;
        to_negedge("b2b.second");
        check("b2b.second_a", alu_a, 16'h0010);
        check("b2b.second_ctrl", alu_ctrl, 5'd1);
        to_posedge();
        step("b2b.drain");

        // ---------------- load-use stall ----------------
        drive_beat(5'd2, 4'd3, 16'h1234, 4'd4, 16'h0044, 4'd5, 8'h00, 1'b0);
        step("lu.cap");
        id_valid        = 1'b0;
        fwd_exm_valid   = 1'b1;
        fwd_exm_is_load = 1'b1;
        fwd_exm_addr    = 4'd3;
        fwd_exm_data    = 16'hDEAD;
        for (int i = 0; i < 2; i++) begin
            to_negedge("lu.stall");
            check("lu.ex_valid", ex_valid, 1'b0);
            check("lu.id_ready", id_ready, 1'b0);
            to_posedge();
        end
        clear_fwd();
        fwd_wb_valid = 1'b1;
        fwd_wb_addr  = 4'd3;
        fwd_wb_data  = 16'hBEEF;
        to_negedge("lu.release");
        check("lu.stall_cnt", stall_cnt, 16'd2);
        check("lu.issue", ex_valid, 1'b1);
        check("lu.alu_a", alu_a, 16'hBEEF);
        to_posedge();
        clear_fwd();
        step("lu.drain");

        // ---------------- forwarding priority and r0 ----------------
        drive_beat(5'd4, 4'd5, 16'h0AAA, 4'd4, 16'h0333, 4'd2, 8'h00, 1'b0);
        step("fp.cap");
        id_valid        = 1'b0;
        fwd_exm_valid   = 1'b1;
        fwd_exm_is_load = 1'b0;
        fwd_exm_addr    = 4'd4;
        fwd_exm_data    = 16'h1111;
        fwd_wb_valid    = 1'b1;
        fwd_wb_addr     = 4'd4;
        fwd_wb_data     = 16'h2222;
        to_negedge("fp.prio");
        check("fp.alu_b", alu_b, 16'h1111);
        check("fp.alu_a", alu_a, 16'h0AAA);
        to_posedge();
        clear_fwd();
        drive_beat(5'd5, 4'd0, 16'h5555, 4'd0, 16'h6666, 4'd1, 8'h00, 1'b0);
        step("r0.cap");
        id_valid      = 1'b0;
        fwd_exm_valid = 1'b1;
        fwd_exm_addr  = 4'd0;
        fwd_exm_data  = 16'hFFFF;
        to_negedge("r0.read");
        check("r0.alu_a", alu_a, 16'h0000);
        check("r0.alu_b", alu_b, 16'h0000);
        to_posedge();
        clear_fwd();

        // ---------------- immediate path ignores rt hazard ----------------
        drive_beat(5'd8, 4'd6, 16'h0101, 4'd5, 16'h0555, 4'd3, 8'h7F, 1'b1);
        step("imm.cap");
        id_valid        = 1'b0;
        fwd_exm_valid   = 1'b1;
        fwd_exm_is_load = 1'b1;
        fwd_exm_addr    = 4'd5;
        to_negedge("imm.issue");
        check("imm.ex_valid", ex_valid, 1'b1);
        check("imm.alu_b", alu_b, 16'h007F);
        check("imm.stall_cnt", stall_cnt, 16'd2);
        to_posedge();
        clear_fwd();

        // ---------------- backpressure then flush ----------------
        drive_beat(5'd3, 4'd1, 16'h00AA, 4'd2, 16'h00BB, 4'd7, 8'h00, 1'b0);
        step("bp.cap");
        ex_ready = 1'b0;
        drive_beat(5'd6, 4'd9, 16'h0999, 4'd10, 16'h0AAA, 4'd11, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            to_negedge("bp.hold");
            check("bp.ex_valid", ex_valid, 1'b1);
            check("bp.id_ready", id_ready, 1'b0);
            check("bp.alu_a", alu_a, 16'h00AA);
            check("bp.alu_b", alu_b, 16'h00BB);
            to_posedge();
        end
        flush = 1'b1;
        to_negedge("fl.cycle");
        check("fl.ex_valid", ex_valid, 1'b0);
        check("fl.id_ready", id_ready, 1'b1);
        to_posedge();
        flush    = 1'b0;
        id_valid = 1'b0;
        ex_ready = 1'b1;
        to_negedge("fl.after");
        check("fl.dropped", ex_valid, 1'b0);
        check("fl.alu_a", alu_a, 16'h0000);
        to_posedge();

        // ---------------- reset during a stall ----------------
        do_reset("pre034");
        drive_beat(5'd2, 4'd3, 16'h0333, 4'd1, 16'h0111, 4'd4, 8'h00, 1'b0);
        step("rs.cap");
        fwd_exm_valid   = 1'b1;
        fwd_exm_is_load = 1'b1;
        fwd_exm_addr    = 4'd3;
        for (int i = 0; i < 5; i++) step("rs.stall");
        check("rs.stall_cnt5", stall_cnt, 16'd5);
        do_reset("rs");
        to_negedge("rs.after");
        check("rs.no_entry", ex_valid, 1'b0);
        to_posedge();
        clear_fwd();
        id_valid = 1'b0;
        step("rs.idle");

        // ---------------- randomized traffic ----------------
        for (int cyc = 0; cyc < 400; cyc++) begin
            id_valid        = ($urandom_range(0, 3) != 0);
            id_ctrl         = 5'($urandom_range(0, 31));
            id_rs_addr      = 4'($urandom_range(0, 3));
            id_rt_addr      = 4'($urandom_range(0, 3));
            id_rd_addr      = 4'($urandom_range(0, 15));
            id_rs_data      = 16'($urandom);
            id_rt_data      = 16'($urandom);
            id_imm          = 8'($urandom);
            id_use_imm      = ($urandom_range(0, 3) == 0);
            id_wr_en        = 1'($urandom);
            flush           = ($urandom_range(0, 15) == 0);
            ex_ready        = ($urandom_range(0, 3) != 0);
            fwd_exm_valid   = 1'($urandom);
            fwd_exm_is_load = 1'($urandom);
            fwd_exm_addr    = 4'($urandom_range(0, 3));
            fwd_exm_data    = 16'($urandom);
            fwd_wb_valid    = 1'($urandom);
            fwd_wb_addr     = 4'($urandom_range(0, 3));
            fwd_wb_data     = 16'($urandom);
            if (cyc == 200) do_reset("rnd");
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have ports: clk in 1, single clock, all state on rising edge.
REQ-002 SHALL have rst_n in 1: one clock; reset is asynchronous and active-low.
REQ-003 SHALL have upstream ports: id_valid in 1, id_ready out 1, id_ctrl in 5, id_rs_addr in 4, id_rt_addr in 4, id_rd_addr in 4, id_rs_data in 16, id_rt_data in 16, id_imm in 8, id_use_imm in 1, id_wr_en in 1.
REQ-004 SHALL have flush in 1, which kills the held entry.
REQ-005 SHALL have EX/MEM forward ports: fwd_exm_valid in 1, fwd_exm_is_load in 1, fwd_exm_addr in 4, fwd_exm_data in 16.
REQ-006 SHALL have WB forward ports: fwd_wb_valid in 1, fwd_wb_addr in 4, fwd_wb_data in 16.
REQ-007 SHALL have ALU-side ports: ex_ready in 1, ex_valid out 1, alu_a out 16, alu_b out 16, alu_ctrl out 5, ex_rd_addr out 4, ex_wr_en out 1.
REQ-008 SHALL have stall_cnt out 16: saturating count of hazard-stall cycles.

Function
REQ-009 SHALL hold one entry: valid bit, ctrl, rs/rt/rd addrs, rs/rt data, imm, use_imm, wr_en.
REQ-010 SHALL define use_rt = !use_imm; register 0 always reads 16'h0000 and is never forwarded or hazard-checked.
REQ-011 SHALL compute hazard = valid && fwd_exm_valid && fwd_exm_is_load && exm_addr!=0 && (exm_addr==rs_addr || (use_rt && exm_addr==rt_addr)).
REQ-012 SHALL drive ex_valid = valid && !hazard && !flush; fire = ex_valid && ex_ready.
REQ-013 SHALL drive id_ready = !valid || fire || flush.
REQ-014 SHALL capture the upstream entry on an edge when id_valid && id_ready && !flush; else clear valid on fire; else hold.
REQ-015 Flush SHALL take priority: valid clears at the next edge, upstream beat in that cycle discarded, no ex_valid in the flush cycle.
REQ-016 SHALL resolve operands combinationally each cycle, per source: exm match (non-load) first, then wb match, then stored data.
REQ-017 SHALL, while the entry is held, overwrite a stored operand with fwd_wb_data at each edge where fwd_wb_valid and the address matches (non-zero), so writes retiring during a stall are not lost.
REQ-018 SHALL, at capture, apply the same WB overwrite to incoming rs/rt data if fwd_wb matches id addresses.
REQ-019 SHALL drive alu_a = resolved rs; alu_b = use_imm ? {8'h00, imm} : resolved rt.
REQ-020 SHALL pass alu_ctrl, ex_rd_addr, ex_wr_en from the entry unmodified; ctrl 8/9 (IMML/IMMH) use the imm path.
REQ-021 SHALL increment stall_cnt by 1 on each edge where valid && hazard && !flush, saturating at 16'hFFFF.
REQ-022 SHALL drive alu_a, alu_b, alu_ctrl, ex_rd_addr, ex_wr_en to 0 whenever valid is 0.
REQ-023 Latency SHALL be 1 cycle: a beat accepted at edge N presents ex_valid in cycle N+1 absent hazard/backpressure.
REQ-024 SHALL sustain one issue per cycle under continuous id_valid and ex_ready with no hazards.
REQ-025 Outputs SHALL remain stable while ex_valid && !ex_ready, except operands updated per REQ-016/017.

Reset
REQ-026 rst_n low SHALL asynchronously clear valid, all stored fields, and stall_cnt to 0.
REQ-027 During reset SHALL drive ex_valid=0, id_ready=1, all data outputs 0.
REQ-028 Reset deassertion mid-stream SHALL leave no entry; first capture needs a fresh id_valid beat.

Verification
REQ-029 Back-to-back: id ctrl=0, rs=1 (0x0005), rt=2 (0x0003), ex_ready=1 -> next cycle ex_valid=1, alu_a=0x0005, alu_b=0x0003, alu_ctrl=0; next beat accepted the same cycle.
REQ-030 Load-use: entry rs=3; fwd_exm_valid=1, is_load=1, addr=3 for 2 cycles -> ex_valid=0, id_ready=0, stall_cnt=2; then wb addr=3 data=0xBEEF -> ex_valid=1, alu_a=0xBEEF.
REQ-031 Forward priority: exm (non-load) addr=4 data=0x1111 and wb addr=4 data=0x2222, rt=4 -> alu_b=0x1111; r0 source with exm addr=0 data=0xFFFF -> operand 0x0000.
REQ-032 Immediate: ctrl=8, use_imm=1, imm=0x7F, rt=5 with exm load addr=5 -> no stall, alu_b=0x007F.
REQ-033 Backpressure/flush: ex_ready=0 for 3 cycles -> outputs stable, id_ready=0; assert flush with id_valid=1 -> next cycle ex_valid=0, incoming beat dropped.
REQ-034 Reset mid-stall with stall_cnt=5 -> immediately ex_valid=0, stall_cnt=0, id_ready=1.
